key_handle_multi: RTL and testbench

- Parametrised multi-channel push-button conditioner for board keys.
- Per channel: N-flop metastability synchroniser, counter-based debouncer, and a one-cycle event pulse on release, press or both, selected at run time.
- Sits between raw key/switch pins and game/control FSMs.
- Legacy single-key release-pulse behaviour is N_KEYS=1, mode=00, DEBOUNCE_CYCLES=1.

---
 rtl/key_handle_multi.sv | 142 ++++++++++++++
 tb/tb_key_handle_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/key_handle_multi.sv
`default_nettype none
// ============================================================================
//  Module   : key_handle_multi
//  Purpose  : Multi-channel key conditioner: synchroniser, counter debouncer,
//             and run-time selectable release/press/both event pulses.
//  Options  : define KEY_AUTOREPEAT_EN to add press auto-repeat (rpt output).
//  Revision : 1.0  initial release
// ============================================================================
module key_handle_multi #(
    parameter int N_KEYS          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] in,
    input  logic [1:0]        mode,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] evt,
    output logic              evt_any,
    output logic [N_KEYS-1:0] rpt
);

    localparam int              c_CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_DB_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam int              c_RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              c_RW       = $clog2(c_RMAX + 1);
    localparam logic [c_RW-1:0] c_RD_LAST  = c_RW'(REPEAT_DELAY - 1);
    localparam logic [c_RW-1:0] c_RP_LAST  = c_RW'(REPEAT_PERIOD - 1);
    logic [N_KEYS-1:0]          w_rpt_nxt;
`endif

    logic              w_rise_en;
    logic              w_fall_en;
    logic [N_KEYS-1:0] w_lvl;
    logic [N_KEYS-1:0] w_evt_nxt;
    logic [N_KEYS-1:0] r_evt;
    logic              r_evt_any;

    // Mode is decoded combinationally so it is qualified at the edge the level moves.
    assign w_fall_en = (mode == 2'b00) || (mode == 2'b10);
    assign w_rise_en = (mode == 2'b01) || (mode == 2'b10);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CW-1:0]        r_cnt;
        logic                   r_lvl;
        logic                   w_s;
        logic                   w_accept;
        logic                   w_rep_pulse;

        assign w_s      = r_sync[SYNC_STAGES-1];
        assign w_accept = (w_s != r_lvl) && (r_cnt == c_DB_LAST);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_lvl  <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], in[i]};
                if ((w_s == r_lvl) || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_lvl <= w_s;
                end
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        logic [c_RW-1:0] r_rcnt;
        logic            r_rph;
        logic            w_rep_hit;

        // Repeat only while the level is held high and not about to change this edge.
        assign w_rep_hit   = r_lvl && !w_accept && (r_rcnt == (r_rph ? c_RP_LAST : c_RD_LAST));
        assign w_rep_pulse = w_rep_hit && w_rise_en;
        assign w_rpt_nxt[i] = w_rep_pulse;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rcnt <= '0;
                r_rph  <= 1'b0;
            end else if (!r_lvl || w_accept) begin
                r_rcnt <= '0;
                r_rph  <= 1'b0;
            end else if (w_rep_hit) begin
                r_rcnt <= '0;
                r_rph  <= 1'b1;
            end else begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end
`else
        assign w_rep_pulse = 1'b0;
`endif

        assign w_lvl[i]     = r_lvl;
        assign w_evt_nxt[i] = (w_accept && w_s && w_rise_en)
                            || (w_accept && !w_s && w_fall_en)
                            || w_rep_pulse;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_evt     <= '0;
            r_evt_any <= 1'b0;
        end else begin
            r_evt     <= w_evt_nxt;
            r_evt_any <= |w_evt_nxt;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    logic [N_KEYS-1:0] r_rpt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rpt <= '0;
        end else begin
            r_rpt <= w_rpt_nxt;
        end
    end

    assign rpt = r_rpt;
`else
    assign rpt = '0;
`endif

    assign level   = w_lvl;
    assign evt     = r_evt;
    assign evt_any = r_evt_any;

endmodule
`default_nettype wire

// File: tb/tb_key_handle_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_handle_multi
//  Purpose  : Scoreboard bench for key_handle_multi (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_handle_multi;

    localparam int c_N   = 4;
    localparam int c_LAT = 2 + 4 - 1;   // SYNC_STAGES + DEBOUNCE_CYCLES - 1

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic       rpt;
    } exp_t;

    logic           clk;
    logic           reset;
    logic [c_N-1:0] in_keys;
    logic [1:0]     mode;
    logic [c_N-1:0] level;
    logic [c_N-1:0] evt;
    logic           evt_any;
    logic [c_N-1:0] rpt;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    key_handle_multi dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in_keys),
        .mode    (mode),
        .level   (level),
        .evt     (evt),
        .evt_any (evt_any),
        .rpt     (rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Event k = next posedge; the event edge is k + c_LAT.
    task automatic push_evt(input logic [3:0] mask, input int offset, input logic is_rpt);
        exp_t e;
        e.cyc  = cyc + 1 + c_LAT + offset;
        e.mask = mask;
        e.rpt  = is_rpt;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the scoreboard, every idle cycle must be quiet.
    always @(negedge clk) begin
        exp_t e;
        if (evt != '0) begin
            if (sb.size() == 0) begin
                check_val("evt_unexpected", 32'(evt), 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("evt_cycle", cyc, e.cyc);
                check_val("evt_mask", 32'(evt), 32'(e.mask));
                check_val("evt_any_hi", 32'(evt_any), 32'd1);
                check_val("rpt_mask", 32'(rpt), e.rpt ? 32'(e.mask) : 32'd0);
            end
        end else begin
            check_val("evt_any_lo", 32'(evt_any), 32'd0);
            check_val("rpt_idle", 32'(rpt), 32'd0);
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check_val("evt_missing", 32'(evt), 32'(e.mask));
            end
        end
    end

    initial begin
        int c0;
        reset   = 1'b0;
        in_keys = '0;
        mode    = 2'b00;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check_val("rst_level", 32'(level), 32'd0);
            check_val("rst_evt", 32'(evt), 32'd0);
        end
        reset = 1'b1;
        wait_cyc(3);
        check_val("post_rst_level", 32'(level), 32'd0);

        // mode 00: press silent, release pulses
        mode    = 2'b00;
        in_keys = 4'b0001;
        wait_cyc(c_LAT);
        check_val("m00_press_early", 32'(level), 32'd0);
        wait_cyc(1);
        check_val("m00_press_level", 32'(level), 32'h1);
        wait_cyc(14);
        in_keys = 4'b0000;
        push_evt(4'b0001, 0, 1'b0);
        wait_cyc(c_LAT);
        check_val("m00_rel_early", 32'(level), 32'h1);
        wait_cyc(1);
        check_val("m00_rel_level", 32'(level), 32'd0);
        wait_cyc(10);

        // mode 01: 3-cycle glitch rejected, 4-cycle pulse accepted
        mode    = 2'b01;
        in_keys = 4'b0010;
        wait_cyc(3);
        in_keys = 4'b0000;
        wait_cyc(10);
        check_val("glitch_level", 32'(level), 32'd0);
        in_keys = 4'b0010;
        c0      = cyc;
        push_evt(4'b0010, 0, 1'b0);
        wait_cyc(4);
        in_keys = 4'b0000;
        wait_cyc(c0 + 1 + c_LAT - cyc);
        check_val("pulse4_level", 32'(level), 32'h2);
        wait_cyc(10);
        check_val("pulse4_rel_level", 32'(level), 32'd0);

        // mode 10: all channels together, both edges
        mode    = 2'b10;
        in_keys = 4'b1111;
        push_evt(4'b1111, 0, 1'b0);
        wait_cyc(15);
        check_val("both_press_level", 32'(level), 32'hF);
        in_keys = 4'b0000;
        push_evt(4'b1111, 0, 1'b0);
        wait_cyc(15);
        check_val("both_rel_level", 32'(level), 32'd0);

        // mode 11: level tracks, no events, mode change alone is silent
        mode    = 2'b11;
        in_keys = 4'b0100;
        wait_cyc(c_LAT);
        check_val("m11_press_early", 32'(level), 32'd0);
        wait_cyc(1);
        check_val("m11_press_level", 32'(level), 32'h4);
        mode = 2'b01;
        wait_cyc(6);
        mode    = 2'b11;
        in_keys = 4'b0000;
        wait_cyc(c_LAT + 1);
        check_val("m11_rel_level", 32'(level), 32'd0);
        wait_cyc(5);

`ifdef KEY_AUTOREPEAT_EN
        // Auto-repeat: press pulse, then +16, +24, +32, +40
        mode    = 2'b01;
        in_keys = 4'b1000;
        push_evt(4'b1000, 0, 1'b0);
        push_evt(4'b1000, 16, 1'b1);
        push_evt(4'b1000, 24, 1'b1);
        push_evt(4'b1000, 32, 1'b1);
        push_evt(4'b1000, 40, 1'b1);
        wait_cyc(c_LAT + 1 + 41);
        in_keys = 4'b0000;
        wait_cyc(25);
        check_val("rpt_rel_level", 32'(level), 32'd0);
`endif

        wait_cyc(3);
        check_val("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
